// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: UART 8N1 receiver that presents each good byte as a time-limited command
module uart_cmd_rx #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int CMD_HOLD   = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       frame_err,
  output logic       busy,
  output logic [7:0] cmd
);
  localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int DW  = DIV > 1 ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int HW  = $clog2(CMD_HOLD);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t          state;
  logic [1:0]      sync;
  logic [DW-1:0]   dcnt;
  logic [SW-1:0]   scnt;
  logic [2:0]      bcnt;
  logic [7:0]      shreg;
  logic [HW-1:0]   hcnt;
  logic            rx_s, tick, half, bit_end, good;
  assign rx_s    = sync[1];
  assign tick    = dcnt == DW'(DIV - 1);
  assign half    = tick && scnt == SW'(OVERSAMPLE / 2 - 1);
  assign bit_end = tick && scnt == SW'(OVERSAMPLE - 1);
  assign good    = state == STOP && bit_end && rx_s;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync <= 2'b11;
      dcnt <= '0;
    end else begin
      sync <= {sync[0], rx};
      dcnt <= tick ? '0 : dcnt + 1'b1;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      scnt      <= '0;
      bcnt      <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE:
          if (!rx_s) begin
            state <= START;
            scnt  <= '0;
            busy  <= 1'b1;
          end
        START:
          if (half) begin
            state <= rx_s ? IDLE : DATA;
            busy  <= !rx_s;
            scnt  <= '0;
            bcnt  <= '0;
          end else if (tick) scnt <= scnt + 1'b1;
        DATA:
          if (bit_end) begin
            shreg <= {rx_s, shreg[7:1]};
            scnt  <= '0;
            bcnt  <= bcnt + 1'b1;
            if (bcnt == 3'd7) state <= STOP;
          end else if (tick) scnt <= scnt + 1'b1;
        STOP:
          if (bit_end) begin
            state     <= IDLE;
            busy      <= 1'b0;
            scnt      <= '0;
            rx_data   <= rx_s ? shreg : rx_data;
            rx_done   <= rx_s;
            frame_err <= !rx_s;
          end else if (tick) scnt <= scnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  // cmd follows rx_data on the same edge, then decays to 0x00 after CMD_HOLD clocks
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cmd  <= '0;
      hcnt <= '0;
    end else if (good) begin
      cmd  <= shreg;
      hcnt <= HW'(CMD_HOLD - 1);
    end else if (hcnt != '0) hcnt <= hcnt - 1'b1;
    else cmd <= '0;
endmodule
